// File: rtl/pc_sequencer.sv
// pc_sequencer: registered, stall-aware fetch PC sequencer.
// It selects between sequential fetch and the decode-stage redirects (jr > jal > beq).
// A redirect that arrives while the PC cannot advance is buffered in PEND.
// Optional macro DELAY_SLOT_EN: MIPS delay-slot semantics. With it, flush_f is tied 0.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        imem_ready,
  input  logic [31:0] d_pc,
  input  logic        beq_take,
  input  logic [15:0] imm16,
  input  logic        jal_take,
  input  logic [25:0] jal_idx,
  input  logic        jr_take,
  input  logic [31:0] jr_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_add4,
  output logic        flush_f,
  output logic        redirect_busy,
  output logic        pc_misalign
);

  typedef enum logic {RUN, PEND} state_t;

  state_t      state, nextState;
  logic [31:0] pendAddr, nextPendAddr, nextPc;
  logic        pendMis, nextPendMis, nextMisalign;
  logic        advance, redirect, targetMis;
  logic [31:0] dPcAdd4, beqTarget, jalTarget, target;

  assign advance  = ~stall & imem_ready;
  assign redirect = jr_take | jal_take | beq_take;
  assign pc_add4  = pc + 32'd4;
  assign dPcAdd4  = d_pc + 32'd4;

  // Redirect target selection, jr > jal > beq; also flag a misaligned jr target
  always_comb begin
    beqTarget = dPcAdd4 + {{14{imm16[15]}}, imm16, 2'b00};
    jalTarget = {dPcAdd4[31:28], jal_idx, 2'b00};
    target    = beqTarget;
    targetMis = 1'b0;
    if (jr_take) begin
      target    = jr_addr;
      targetMis = |jr_addr[1:0];
    end else if (jal_take) begin
      target = jalTarget;
    end
  end

  // Next-state and next-PC logic for RUN/PEND
  always_comb begin
    nextState    = state;
    nextPc       = pc;
    nextPendAddr = pendAddr;
    nextPendMis  = pendMis;
    nextMisalign = pc_misalign;
    unique case (state)
      RUN: begin
        if (advance) begin
          if (redirect) begin
            nextPc       = target;
            nextMisalign = pc_misalign | targetMis;
          end else begin
            nextPc = pc_add4;
          end
        end else if (redirect) begin
          nextPendAddr = target;
          nextPendMis  = targetMis;
          nextState    = PEND;
        end
      end
      PEND: begin
        if (advance) begin
          nextState = RUN;
          if (redirect) begin
            nextPc       = target;
            nextMisalign = pc_misalign | targetMis;
          end else begin
            nextPc       = pendAddr;
            nextMisalign = pc_misalign | pendMis;
          end
        end else if (redirect) begin
          // newest redirect replaces the buffered one
          nextPendAddr = target;
          nextPendMis  = targetMis;
        end
      end
      default: nextState = RUN;
    endcase
  end

  // State registers; synchronous reset discards any pending redirect
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      pc          <= RESET_PC;
      pendAddr    <= '0;
      pendMis     <= 1'b0;
      pc_misalign <= 1'b0;
    end else begin
      state       <= nextState;
      pc          <= nextPc;
      pendAddr    <= nextPendAddr;
      pendMis     <= nextPendMis;
      pc_misalign <= nextMisalign;
    end
  end

  assign redirect_busy = (state == PEND);

`ifdef DELAY_SLOT_EN
  // the instruction after a branch is the delay slot, so it is never killed
  assign flush_f = 1'b0;
`else
  // kill the wrong-path fetch at the same edge the PC is redirected
  assign flush_f = ~reset & advance & (redirect | (state == PEND));
`endif

endmodule
